icache_direct: RTL and testbench
================================

Name: icache_direct

Overview:
- Direct-mapped, read-allocate instruction cache between the MIPS core's instruction sram-like port and the AXI bridge's instruction sram-like port.
- Hits are served from internal storage.
- Misses refill one line as LINE_WORDS sequential single-word sram-like reads.
- Uncached addresses (kseg1, addr[31:29]==3'b101) and writes bypass the cache as single pass-through transactions.

Parameters:
INDEX_WIDTH, 6, log2 of set count (64 sets)
OFFSET_WIDTH, 4, log2 of line bytes (16 B = 4 words); LINE_WORDS = 2^(OFFSET_WIDTH-2); TAG_WIDTH = 32-INDEX_WIDTH-OFFSET_WIDTH

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
cpu_req  in  1  core request; held until cpu_addr_ok
cpu_wr  in  1  1=write (always bypass)
cpu_size  in  2  0=byte,1=half,2=word
cpu_addr  in  32  byte address
cpu_wdata  in  32  write data
cpu_rdata  out  32  read data, valid with cpu_data_ok
cpu_addr_ok  out  1  request accepted this cycle
cpu_data_ok  out  1  one-cycle completion pulse
mem_req  out  1  memory-side request
mem_wr  out  1  memory-side write
mem_size  out  2  memory-side size
mem_addr  out  32  memory-side address
mem_wdata  out  32  memory-side write data
mem_rdata  in  32  memory-side read data
mem_addr_ok  in  1  memory-side accept
mem_data_ok  in  1  memory-side completion

Behaviour:
- Reset, asynchronous on resetn low: state=IDLE; all valid bits=0; cpu_addr_ok=0 outside IDLE; cpu_data_ok=0; cpu_rdata=0; mem_req=0; mem_wr=0; mem_size=0; mem_addr=0; mem_wdata=0; refill counter=0. Tag/data arrays are not reset.
- Reset mid-refill or mid-bypass abandons the transaction; the line stays invalid. The AXI bridge shares the reset, so no stale mem_data_ok is expected.
- One outstanding core request at a time. Handshake = cpu_req & cpu_addr_ok.
- cpu_addr_ok = (state==IDLE), combinational. On handshake, latch addr, wr, size and wdata.
- States:
  - IDLE: on handshake -> LOOKUP if read and cached, else BYP_REQ.
  - LOOKUP: hit = valid[idx] & tag[idx]==req_tag.
    - Hit: cpu_data_ok=1, cpu_rdata=data[idx][word] this cycle -> IDLE. Hit latency = 1 cycle after handshake.
    - Miss: counter=0 -> REF_REQ.
  - REF_REQ: mem_req=1, mem_wr=0, mem_size=2, mem_addr={req_tag,idx,counter,2'b00}. On mem_addr_ok -> REF_WAIT (mem_req low).
  - REF_WAIT: on mem_data_ok, write mem_rdata to data[idx][counter].
    - If counter==LINE_WORDS-1: valid[idx]=1, tag[idx]=req_tag -> RESP.
    - Else counter+1 -> REF_REQ.
    - Refill always starts at word 0 and wraps nowhere. Valid is set only after the last word.
  - RESP: cpu_data_ok=1, cpu_rdata=data[idx][req word] -> IDLE.
  - BYP_REQ: mem_req=1 with latched addr/wr/size/wdata. On mem_addr_ok -> BYP_WAIT.
    - For a cached-region write that hits, clear valid[idx] in the same cycle (no write-allocate, no update).
  - BYP_WAIT: on mem_data_ok, register mem_rdata (write: don't care) -> RESP_BYP.
  - RESP_BYP: cpu_data_ok=1, cpu_rdata=registered data -> IDLE.
- mem_req drops in the cycle after mem_addr_ok; never two memory requests in flight.
- mem_addr_ok and mem_data_ok asserting in the same cycle for the same request: treat as accept then complete. The FSM must consume the data_ok in REF_WAIT/BYP_WAIT the next cycle at the earliest. The memory side never does this; assert it in simulation.
- Uncached-region reads never allocate and never probe (no hit from a stale line).
- Index/offset extraction: idx=addr[OFFSET_WIDTH+INDEX_WIDTH-1:OFFSET_WIDTH], word=addr[OFFSET_WIDTH-1:2]. cpu_addr[1:0] passes through on bypass only.
- Cached reads return the full word regardless of cpu_size; the core extracts bytes.

Test Plan:
- Cold miss: after reset, read 0x9FC0_0010 -> four mem reads at 0x9FC0_0010, _0014, _0018, _001C. Memory returns 0x11,0x22,0x33,0x44 -> one cpu_data_ok with rdata=0x11; valid[1]=1.
- Hit: then read 0x9FC0_0018 -> cpu_data_ok exactly 1 cycle after handshake, rdata=0x33, no mem_req.
- Conflict: read 0x9FC0_0410 (same index 1, different tag) -> 4-word refill replaces the line; re-read 0x9FC0_0010 misses again.
- Uncached: read 0xBFC0_0010 twice -> two single mem reads, mem_size=2, each rdata forwarded; valid bits unchanged.
- Write invalidate: write 0x9FC0_0014 data 0xDEAD, size 2 -> one mem write with wr=1, wdata=0xDEAD; line 1 invalidated; next read 0x9FC0_0010 refills.
- Reset mid-refill: drop resetn after 2nd word of a refill -> outputs at reset values the same cycle. After release, same address misses and refills all 4 words.

Source files
------------

// File: rtl/icache_direct_if.sv
`default_nettype none
// ============================================================================
// icache_direct_if : sram-like request/response bus (core side and bridge side)
// Rev 1.0
// ============================================================================
interface icache_direct_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;

  modport master (output req, wr, size, addr, wdata, input rdata, addr_ok, data_ok);
  modport slave  (input req, wr, size, addr, wdata, output rdata, addr_ok, data_ok);
endinterface
`default_nettype wire

// File: rtl/icache_direct.sv
`default_nettype none
// ============================================================================
// icache_direct : direct-mapped read-allocate instruction cache, sram-like ports
// Rev 1.0
// ============================================================================
module icache_direct #(
  parameter int INDEX_WIDTH  = 6,
  parameter int OFFSET_WIDTH = 4
) (
  input  wire logic       clk,
  input  wire logic       resetn,
  icache_direct_if.slave  cpu,
  icache_direct_if.master mem
);
  localparam int WORD_WIDTH = OFFSET_WIDTH - 2;
  localparam int LINE_WORDS = 1 << WORD_WIDTH;
  localparam int TAG_WIDTH  = 32 - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int SETS       = 1 << INDEX_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_REF_REQ, S_REF_WAIT, S_RESP, S_BYP_REQ, S_BYP_WAIT, S_RESP_BYP
  } state_t;

  state_t r_state, w_next;

  logic [31:0]           r_addr, r_wdata, r_byp_data;
  logic                  r_wr;
  logic [1:0]            r_size;
  logic [WORD_WIDTH-1:0] r_cnt;
  logic [SETS-1:0]       r_valid;
  logic [TAG_WIDTH-1:0]  r_tag  [SETS];
  logic [31:0]           r_data [SETS*LINE_WORDS];

  logic [INDEX_WIDTH-1:0] w_idx;
  logic [WORD_WIDTH-1:0]  w_word;
  logic [TAG_WIDTH-1:0]   w_tag;
  logic                   w_uncached, w_hit, w_handshake;
  logic                   w_fill, w_fill_last, w_inval;
  logic [31:0]            w_line_word;

  assign w_idx       = r_addr[OFFSET_WIDTH+INDEX_WIDTH-1:OFFSET_WIDTH];
  assign w_word      = r_addr[OFFSET_WIDTH-1:2];
  assign w_tag       = r_addr[31:OFFSET_WIDTH+INDEX_WIDTH];
  assign w_uncached  = (r_addr[31:29] == 3'b101);
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_handshake = cpu.req && (r_state == S_IDLE);
  assign w_fill      = (r_state == S_REF_WAIT) && mem.data_ok;
  assign w_fill_last = w_fill && (&r_cnt);
  // Writes to a cached line drop it rather than patch it (no write-allocate).
  assign w_inval     = (r_state == S_BYP_REQ) && r_wr && !w_uncached && w_hit;
  assign w_line_word = r_data[{w_idx, w_word}];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr     <= '0;
      r_wr       <= 1'b0;
      r_size     <= '0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_valid    <= '0;
      r_byp_data <= '0;
    end else begin
      if (w_handshake) begin
        r_addr  <= cpu.addr;
        r_wr    <= cpu.wr;
        r_size  <= cpu.size;
        r_wdata <= cpu.wdata;
      end
      if (r_state == S_LOOKUP)      r_cnt <= '0;
      else if (w_fill && !w_fill_last) r_cnt <= r_cnt + 1'b1;
      if (w_fill_last) r_valid[w_idx] <= 1'b1;
      if (w_inval)     r_valid[w_idx] <= 1'b0;
      if ((r_state == S_BYP_WAIT) && mem.data_ok) r_byp_data <= mem.rdata;
    end
  end

  // Tag/data storage carries no reset; validity alone gates hits.
  always_ff @(posedge clk) begin
    if (w_fill)      r_data[{w_idx, r_cnt}] <= mem.rdata;
    if (w_fill_last) r_tag[w_idx]           <= w_tag;
  end

  always_comb begin
    w_next      = r_state;
    cpu.addr_ok = 1'b0;
    cpu.data_ok = 1'b0;
    cpu.rdata   = '0;
    mem.req     = 1'b0;
    mem.wr      = 1'b0;
    mem.size    = 2'd0;
    mem.addr    = '0;
    mem.wdata   = '0;
    case (r_state)
      S_IDLE: begin
        cpu.addr_ok = 1'b1;
        if (cpu.req)
          w_next = (!cpu.wr && (cpu.addr[31:29] != 3'b101)) ? S_LOOKUP : S_BYP_REQ;
      end
      S_LOOKUP: begin
        if (w_hit) begin
          cpu.data_ok = 1'b1;
          cpu.rdata   = w_line_word;
          w_next      = S_IDLE;
        end else begin
          w_next = S_REF_REQ;
        end
      end
      S_REF_REQ: begin
        mem.req  = 1'b1;
        mem.size = 2'd2;
        mem.addr = {w_tag, w_idx, r_cnt, 2'b00};
        if (mem.addr_ok) w_next = S_REF_WAIT;
      end
      S_REF_WAIT: begin
        if (mem.data_ok) w_next = (&r_cnt) ? S_RESP : S_REF_REQ;
      end
      S_RESP: begin
        cpu.data_ok = 1'b1;
        cpu.rdata   = w_line_word;
        w_next      = S_IDLE;
      end
      S_BYP_REQ: begin
        mem.req   = 1'b1;
        mem.wr    = r_wr;
        mem.size  = r_size;
        mem.addr  = r_addr;
        mem.wdata = r_wdata;
        if (mem.addr_ok) w_next = S_BYP_WAIT;
      end
      S_BYP_WAIT: begin
        if (mem.data_ok) w_next = S_RESP_BYP;
      end
      S_RESP_BYP: begin
        cpu.data_ok = 1'b1;
        cpu.rdata   = r_byp_data;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // The bridge never accepts and completes a request in the same cycle.
  a_no_ok_overlap: assert property (@(posedge clk) disable iff (!resetn)
    !(mem.addr_ok && mem.data_ok));

endmodule
`default_nettype wire

// File: tb/tb_icache_direct.sv
`default_nettype none
// ============================================================================
// tb_icache_direct : directed self-checking bench with a one-request memory model
// Rev 1.0
// ============================================================================
module tb_icache_direct;
  logic clk;
  logic resetn;
  int   errors = 0;
  int   checks = 0;

  icache_direct_if cpu_bus ();
  icache_direct_if mem_bus ();

  icache_direct #(.INDEX_WIDTH(6), .OFFSET_WIDTH(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .cpu    (cpu_bus),
    .mem    (mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] log_addr  [$];
  logic [31:0] log_wdata [$];
  logic        log_wr    [$];
  logic [1:0]  log_size  [$];
  int          n_req  = 0;
  int          n_data = 0;

  // Memory word pattern: region nibble, line bits [11:4], 0x11*(word+1)
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [7:0] lo;
    lo = 8'h11 * ({6'd0, a[3:2]} + 8'd1);
    return {a[31:28], 4'h0, a[11:4], 8'h00, lo};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Memory model: accept a request, complete it on the following cycle
  initial begin
    logic        pend;
    logic [31:0] pend_rd;
    pend = 1'b0;
    pend_rd = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        mem_bus.addr_ok = 1'b0;
        mem_bus.data_ok = 1'b0;
        mem_bus.rdata   = '0;
        pend = 1'b0;
      end else begin
        mem_bus.addr_ok = 1'b0;
        mem_bus.data_ok = 1'b0;
        if (pend) begin
          mem_bus.data_ok = 1'b1;
          mem_bus.rdata   = pend_rd;
          pend = 1'b0;
          n_data++;
        end else if (mem_bus.req) begin
          mem_bus.addr_ok = 1'b1;
          pend    = 1'b1;
          pend_rd = mem_word(mem_bus.addr);
          log_addr.push_back(mem_bus.addr);
          log_wdata.push_back(mem_bus.wdata);
          log_wr.push_back(mem_bus.wr);
          log_size.push_back(mem_bus.size);
          n_req++;
        end
      end
    end
  end

  function automatic logic [31:0] log_a(input int i);
    return (i < log_addr.size()) ? log_addr[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic cpu_access(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rdata, output int lat);
    int n;
    @(negedge clk);
    cpu_bus.req   = 1'b1;
    cpu_bus.wr    = wr;
    cpu_bus.size  = size;
    cpu_bus.addr  = addr;
    cpu_bus.wdata = wdata;
    n = 0;
    while (!cpu_bus.addr_ok && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val($sformatf("handshake_%08h", addr), 32'(n < 100), 32'd1);
    @(posedge clk);
    #1 cpu_bus.req = 1'b0;
    lat = 0;
    rdata = '0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (cpu_bus.data_ok) begin
        rdata = cpu_bus.rdata;
        break;
      end
    end
    check_val($sformatf("done_%08h", addr), 32'(lat < 200), 32'd1);
    @(negedge clk);
    check_val($sformatf("pulse_%08h", addr), 32'(cpu_bus.data_ok), 32'd0);
  endtask

  task automatic check_refill(input string tag, input int base, input logic [31:0] line);
    check_val({tag, "_nreq"}, 32'(n_req - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("%s_addr%0d", tag, i), log_a(base + i), line + 32'(4 * i));
      if (base + i < log_wr.size())
        check_val($sformatf("%s_wr%0d", tag, i), 32'(log_wr[base + i]), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] rd;
    int          lat, base, dbase, n;

    resetn          = 1'b0;
    cpu_bus.req     = 1'b0;
    cpu_bus.wr      = 1'b0;
    cpu_bus.size    = 2'd0;
    cpu_bus.addr    = '0;
    cpu_bus.wdata   = '0;
    mem_bus.addr_ok = 1'b0;
    mem_bus.data_ok = 1'b0;
    mem_bus.rdata   = '0;

    #2;
    check_val("rst_data_ok", 32'(cpu_bus.data_ok), 32'd0);
    check_val("rst_rdata",   cpu_bus.rdata, 32'd0);
    check_val("rst_mem_req", 32'(mem_bus.req), 32'd0);
    check_val("rst_mem_addr", mem_bus.addr, 32'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    #1 check_val("idle_addr_ok", 32'(cpu_bus.addr_ok), 32'd1);

    // Cold miss on index 1
    base = n_req;
    cpu_access(1'b0, 2'd2, 32'h9FC0_0010, '0, rd, lat);
    check_refill("cold", base, 32'h9FC0_0010);
    check_val("cold_rdata", rd, 32'h9001_0011);
    check_val("cold_size", 32'(log_size[base]), 32'd2);

    // Hit one cycle after handshake
    base = n_req;
    cpu_access(1'b0, 2'd2, 32'h9FC0_0018, '0, rd, lat);
    check_val("hit_rdata", rd, 32'h9001_0033);
    check_val("hit_lat", 32'(lat), 32'd1);
    check_val("hit_nreq", 32'(n_req - base), 32'd0);

    // Conflict on index 1, then the old line misses again
    base = n_req;
    cpu_access(1'b0, 2'd2, 32'h9FC0_0410, '0, rd, lat);
    check_refill("conf", base, 32'h9FC0_0410);
    check_val("conf_rdata", rd, 32'h9041_0011);
    base = n_req;
    cpu_access(1'b0, 2'd2, 32'h9FC0_0010, '0, rd, lat);
    check_refill("rerd", base, 32'h9FC0_0010);
    check_val("rerd_rdata", rd, 32'h9001_0011);
    base = n_req;
    cpu_access(1'b0, 2'd2, 32'h9FC0_001C, '0, rd, lat);
    check_val("hit2_rdata", rd, 32'h9001_0044);
    check_val("hit2_nreq", 32'(n_req - base), 32'd0);

    // Uncached reads: one pass-through each, cache untouched
    for (int k = 0; k < 2; k++) begin
      base = n_req;
      cpu_access(1'b0, 2'd2, 32'hBFC0_0010, '0, rd, lat);
      check_val($sformatf("unc%0d_nreq", k), 32'(n_req - base), 32'd1);
      check_val($sformatf("unc%0d_addr", k), log_a(base), 32'hBFC0_0010);
      check_val($sformatf("unc%0d_size", k), 32'(log_size[base]), 32'd2);
      check_val($sformatf("unc%0d_rdata", k), rd, 32'hB001_0011);
    end
    base = n_req;
    cpu_access(1'b0, 2'd0, 32'hBFC0_0013, '0, rd, lat);
    check_val("uncb_addr", log_a(base), 32'hBFC0_0013);
    check_val("uncb_size", 32'(log_size[base]), 32'd0);
    check_val("uncb_rdata", rd, 32'hB001_0011);
    base = n_req;
    cpu_access(1'b0, 2'd2, 32'h9FC0_0014, '0, rd, lat);
    check_val("hit3_rdata", rd, 32'h9001_0022);
    check_val("hit3_nreq", 32'(n_req - base), 32'd0);

    // Write bypasses and invalidates the line
    base = n_req;
    cpu_access(1'b1, 2'd2, 32'h9FC0_0014, 32'h0000_DEAD, rd, lat);
    check_val("wr_nreq", 32'(n_req - base), 32'd1);
    check_val("wr_addr", log_a(base), 32'h9FC0_0014);
    check_val("wr_wr", 32'(log_wr[base]), 32'd1);
    check_val("wr_wdata", log_wdata[base], 32'h0000_DEAD);
    check_val("wr_size", 32'(log_size[base]), 32'd2);
    base = n_req;
    cpu_access(1'b0, 2'd2, 32'h9FC0_0010, '0, rd, lat);
    check_refill("winv", base, 32'h9FC0_0010);
    check_val("winv_rdata", rd, 32'h9001_0011);

    // Reset after the second refill word lands
    base  = n_req;
    dbase = n_data;
    @(negedge clk);
    cpu_bus.req  = 1'b1;
    cpu_bus.wr   = 1'b0;
    cpu_bus.size = 2'd2;
    cpu_bus.addr = 32'h9FC0_0020;
    @(posedge clk);
    #1 cpu_bus.req = 1'b0;
    n = 0;
    while (n_data < dbase + 2 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check_val("mrst_wait", 32'(n < 200), 32'd1);
    #1 resetn = 1'b0;
    #1;
    check_val("mrst_mem_req",  32'(mem_bus.req), 32'd0);
    check_val("mrst_mem_addr", mem_bus.addr, 32'd0);
    check_val("mrst_mem_size", 32'(mem_bus.size), 32'd0);
    check_val("mrst_data_ok",  32'(cpu_bus.data_ok), 32'd0);
    check_val("mrst_nreq",     32'(n_req - base), 32'd2);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    base = n_req;
    cpu_access(1'b0, 2'd2, 32'h9FC0_0020, '0, rd, lat);
    check_refill("mrst", base, 32'h9FC0_0020);
    check_val("mrst_rdata", rd, 32'h9002_0011);
    base = n_req;
    cpu_access(1'b0, 2'd2, 32'h9FC0_0028, '0, rd, lat);
    check_val("mrst_hit_rdata", rd, 32'h9002_0033);
    check_val("mrst_hit_nreq", 32'(n_req - base), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
`default_nettype wire
